cache_write_interface: RTL and testbench
========================================

Name: cache_write_interface

Overview:
- Write-side counterpart of the cache read path.
- Accepts write transactions: a header (id, addr, len), then a stream of IWIDTH-wide data beats.
- Serializes each beat into CWIDTH cache-SRAM writes using the active-low ce/we cache port, with wrapping addresses inside a cache line.
- Reports per-transfer completion to MemC and diverts MMIO transfers to a side output instead of the cache.

Parameters:
- ADDR_BITS, 10: cache SRAM address width, in CWIDTH-word units.
- LEN_BITS, 8: width of the length field.
- IWIDTH, 128: streaming beat width; must be a multiple of CWIDTH.
- CWIDTH, 32: cache data port width.
- ID_LEN, 2: transaction id width.
- WRAP_BITS, 4: log2 of cache line size in CWIDTH words; the address wraps within this field.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- OUT_ready  out  1  header slot available
- IN_valid  in  1  header valid
- IN_id  in  ID_LEN  transaction id
- IN_len  in  LEN_BITS  number of CWIDTH words minus 1
- IN_addr  in  ADDR_BITS  start word address
- IN_mmio  in  1  MMIO transfer; no cache write
- IN_dataValid  in  1  data beat valid
- OUT_dataReady  out  1  data beat accepted when high with IN_dataValid
- IN_data  in  IWIDTH  beat; word 0 in bits [CWIDTH-1:0]
- IN_last  in  1  final beat of transfer
- IN_CACHE_ready  in  1  cache port grants the access this cycle
- OUT_CACHE_ce  out  1  chip enable, active low
- OUT_CACHE_we  out  1  write enable, active low
- OUT_CACHE_addr  out  ADDR_BITS  cache address
- OUT_CACHE_data  out  CWIDTH  write data
- OUT_mmioValid  out  1  one-cycle pulse: MMIO data captured
- OUT_mmioData  out  32  MMIO write data
- OUT_done  out  1  one-cycle pulse: transfer complete
- OUT_doneId  out  ID_LEN  id of completed transfer

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Reset values:
  - Transfer slots and beat buffer are invalid; word index and progress are 0.
  - OUT_CACHE_ce=1, OUT_CACHE_we=1.
  - OUT_done=0, OUT_mmioValid=0.
  - OUT_ready=1, OUT_dataReady=1.
  - Data outputs are don't-care while their valid is low.
- Transfer slots (cur, next):
  - A header is accepted when IN_valid && OUT_ready and loads into cur if cur is free, else into next.
  - OUT_ready = !next.valid || (cur finishes this cycle).
  - When cur finishes, next moves to cur, or a header arriving that same cycle goes straight to cur.
  - Transfers complete strictly in header order.
- Beat buffer (one IWIDTH register plus a word index wi, 0..WNUM-1, WNUM = IWIDTH/CWIDTH):
  - OUT_dataReady = buffer empty, or its final useful word is being written (or consumed as MMIO) this cycle. This allows back-to-back beats at full cache bandwidth.
  - A beat arriving while cur is invalid is still buffered; it binds to the next header.
- Cache write, issued combinationally when cur.valid && !cur.mmio && buffer valid:
  - OUT_CACHE_ce=0, OUT_CACHE_we=0.
  - OUT_CACHE_data = buffer word wi.
  - OUT_CACHE_addr = {cur.addr[ADDR_BITS-1:WRAP_BITS], (cur.addr[WRAP_BITS-1:0] + progress[WRAP_BITS-1:0]) mod 2^WRAP_BITS}.
  - Address, data and control are held stable until IN_CACHE_ready.
  - A write succeeds when the cycle has IN_CACHE_ready=1; on success, progress++ and wi++.
- Completion:
  - The transfer finishes on the successful write with progress == cur.len.
  - Any remaining words of that beat are discarded and the buffer is freed.
  - If wi reaches WNUM-1 without finishing, the buffer frees and wi returns to 0.
  - OUT_done/OUT_doneId are registered: they pulse in the cycle after the finishing write.
  - IN_last must accompany the beat containing word cur.len; this is asserted in simulation.
- MMIO transfers (cur.mmio):
  - No cache access is made; IN_len is ignored.
  - The first buffered beat's [31:0] goes to OUT_mmioData, with an OUT_mmioValid pulse (registered, 1 cycle latency).
  - The beat is consumed and the transfer finishes, so OUT_done pulses in the same cycle as OUT_mmioValid.
- Widths:
  - progress is LEN_BITS wide; len up to 2^LEN_BITS-1.
  - Address low bits wrap modulo the line size, and the upper bits never change within a transfer.
- Simultaneous events:
  - Header acceptance, beat acceptance, a cache write, and finish with next→cur promotion may all occur in one cycle without loss.
  - A new cur begins issuing in the following cycle.
- Reset mid-transfer: state is discarded, any in-flight write is abandoned (ce=1 the following cycle), and no done pulse is emitted.

Test Plan:
- Header addr=0x020, len=3, one beat 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, IN_CACHE_ready=1 -> writes at 0x020..0x023 with AAAA..DDDD on 4 consecutive cycles; OUT_done with the id on the 5th.
- Wrap: addr=0x03E, len=3 -> addresses 0x03E, 0x03F, 0x030, 0x031.
- Stall: IN_CACHE_ready low for 3 cycles on word 1 -> addr/data held, no progress, done delayed 3 cycles; len=1 beat -> words 2-3 dropped.
- Back-to-back: two headers (id 1 len 7, id 2 len 3) with 3 beats streamed -> 12 gapless writes, OUT_ready low only while both slots are full, done id1 then id2.
- MMIO: header mmio=1, beat [31:0]=0x12345678 -> no ce=0 cycles; OUT_mmioValid, mmioData=0x12345678 and OUT_done pulse together one cycle after consumption.
- rst asserted after 2 of 4 writes -> ce=1 next cycle, OUT_ready=1, no OUT_done.

Source files
------------

// File: rtl/cache_write_interface.sv
// Cache write interface: queues up to two write headers, buffers one data beat and
// serializes it onto the active-low cache SRAM port; MMIO transfers go to a side output.
module cache_write_interface #(
   parameter int ADDR_BITS = 10,
   parameter int LEN_BITS  = 8,
   parameter int IWIDTH    = 128,
   parameter int CWIDTH    = 32,
   parameter int ID_LEN    = 2,
   parameter int WRAP_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 OUT_ready,
   input  logic                 IN_valid,
   input  logic [ID_LEN-1:0]    IN_id,
   input  logic [LEN_BITS-1:0]  IN_len,
   input  logic [ADDR_BITS-1:0] IN_addr,
   input  logic                 IN_mmio,
   input  logic                 IN_dataValid,
   output logic                 OUT_dataReady,
   input  logic [IWIDTH-1:0]    IN_data,
   input  logic                 IN_last,
   input  logic                 IN_CACHE_ready,
   output logic                 OUT_CACHE_ce,
   output logic                 OUT_CACHE_we,
   output logic [ADDR_BITS-1:0] OUT_CACHE_addr,
   output logic [CWIDTH-1:0]    OUT_CACHE_data,
   output logic                 OUT_mmioValid,
   output logic [31:0]          OUT_mmioData,
   output logic                 OUT_done,
   output logic [ID_LEN-1:0]    OUT_doneId
);
   localparam int WNUM    = IWIDTH / CWIDTH;
   localparam int WI_BITS = (WNUM > 1) ? $clog2(WNUM) : 1;
   localparam logic [WI_BITS-1:0] WI_LAST = WI_BITS'(WNUM - 1);

   typedef struct packed {
      logic                 valid;
      logic                 mmio;
      logic [ID_LEN-1:0]    id;
      logic [ADDR_BITS-1:0] addr;
      logic [LEN_BITS-1:0]  len;
   } slot_t;

   slot_t cur, nxt, hdr;

   logic                 buf_valid;
   logic                 buf_last;
   logic [IWIDTH-1:0]    buf_data;
   logic [WI_BITS-1:0]   wi;
   logic [LEN_BITS-1:0]  progress;

   logic write_en, write_ok, finish_wr, mmio_take, cur_finish, buf_free;
   logic hdr_acc, beat_acc;
   logic [WRAP_BITS-1:0] wrap_lo;

   always_comb begin
      hdr.valid = 1'b1;
      hdr.mmio  = IN_mmio;
      hdr.id    = IN_id;
      hdr.addr  = IN_addr;
      hdr.len   = IN_len;
   end

   always_comb begin
      write_en   = cur.valid && !cur.mmio && buf_valid;
      write_ok   = write_en && IN_CACHE_ready;
      finish_wr  = write_ok && (progress == cur.len);
      mmio_take  = cur.valid && cur.mmio && buf_valid;
      cur_finish = finish_wr || mmio_take;
      // The beat is released on its last word, or early when the transfer ends inside it.
      buf_free   = cur_finish || (write_ok && (wi == WI_LAST));
   end

   assign OUT_ready     = !nxt.valid || cur_finish;
   assign OUT_dataReady = !buf_valid || buf_free;
   assign hdr_acc       = IN_valid && OUT_ready;
   assign beat_acc      = IN_dataValid && OUT_dataReady;
   assign wrap_lo       = cur.addr[WRAP_BITS-1:0] + progress[WRAP_BITS-1:0];

   always_comb begin
      OUT_CACHE_ce   = !write_en;
      OUT_CACHE_we   = !write_en;
      OUT_CACHE_addr = {cur.addr[ADDR_BITS-1:WRAP_BITS], wrap_lo};
      OUT_CACHE_data = buf_data[CWIDTH*int'(wi) +: CWIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur           <= '0;
         nxt           <= '0;
         buf_valid     <= 1'b0;
         buf_last      <= 1'b0;
         wi            <= '0;
         progress      <= '0;
         OUT_done      <= 1'b0;
         OUT_mmioValid <= 1'b0;
      end else begin
         OUT_done      <= cur_finish;
         OUT_doneId    <= cur.id;
         OUT_mmioValid <= mmio_take;
         OUT_mmioData  <= buf_data[31:0];

         if (cur_finish) begin
            progress <= '0;
            if (nxt.valid) begin
               cur <= nxt;
               nxt <= hdr_acc ? hdr : '0;
            end else begin
               cur <= hdr_acc ? hdr : '0;
            end
         end else begin
            if (write_ok)
               progress <= progress + LEN_BITS'(1);
            if (hdr_acc) begin
               if (!cur.valid)
                  cur <= hdr;
               else
                  nxt <= hdr;
            end
         end

         if (buf_free)
            wi <= '0;
         else if (write_ok)
            wi <= wi + WI_BITS'(1);

         if (beat_acc) begin
            buf_valid <= 1'b1;
            buf_data  <= IN_data;
            buf_last  <= IN_last;
         end else if (buf_free) begin
            buf_valid <= 1'b0;
         end
      end
   end

   // The beat holding word cur.len must have been flagged as the last beat.
   assert property (@(posedge clk) disable iff (rst) finish_wr |-> buf_last);

endmodule

// File: tb/tb_cache_write_interface.sv
// Scoreboard bench for cache_write_interface: a transfer-level model queues the expected
// cache writes, MMIO captures and done ids; a negedge monitor compares what the DUT emits.
module tb_cache_write_interface;
   localparam int ADDR_BITS = 10;
   localparam int LEN_BITS  = 8;
   localparam int IWIDTH    = 128;
   localparam int CWIDTH    = 32;
   localparam int ID_LEN    = 2;
   localparam int WRAP_BITS = 4;
   localparam int WNUM      = IWIDTH / CWIDTH;
   localparam int LINE      = 1 << WRAP_BITS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic                 OUT_ready, IN_valid, IN_mmio, IN_dataValid, OUT_dataReady, IN_last;
   logic [ID_LEN-1:0]    IN_id, OUT_doneId;
   logic [LEN_BITS-1:0]  IN_len;
   logic [ADDR_BITS-1:0] IN_addr, OUT_CACHE_addr;
   logic [IWIDTH-1:0]    IN_data;
   logic                 IN_CACHE_ready, OUT_CACHE_ce, OUT_CACHE_we, OUT_mmioValid, OUT_done;
   logic [CWIDTH-1:0]    OUT_CACHE_data;
   logic [31:0]          OUT_mmioData;

   always #5 clk = ~clk;

   cache_write_interface #(
      .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .IWIDTH(IWIDTH),
      .CWIDTH(CWIDTH), .ID_LEN(ID_LEN), .WRAP_BITS(WRAP_BITS)
   ) dut (
      .clk(clk), .rst(rst),
      .OUT_ready(OUT_ready), .IN_valid(IN_valid), .IN_id(IN_id), .IN_len(IN_len),
      .IN_addr(IN_addr), .IN_mmio(IN_mmio),
      .IN_dataValid(IN_dataValid), .OUT_dataReady(OUT_dataReady), .IN_data(IN_data),
      .IN_last(IN_last), .IN_CACHE_ready(IN_CACHE_ready),
      .OUT_CACHE_ce(OUT_CACHE_ce), .OUT_CACHE_we(OUT_CACHE_we),
      .OUT_CACHE_addr(OUT_CACHE_addr), .OUT_CACHE_data(OUT_CACHE_data),
      .OUT_mmioValid(OUT_mmioValid), .OUT_mmioData(OUT_mmioData),
      .OUT_done(OUT_done), .OUT_doneId(OUT_doneId)
   );

   typedef struct {logic [ADDR_BITS-1:0] addr; logic [CWIDTH-1:0] data; bit last;} wr_t;
   typedef struct {logic [ID_LEN-1:0] id; bit mmio;} done_t;
   typedef struct {logic [ID_LEN-1:0] id; logic [ADDR_BITS-1:0] addr; logic [LEN_BITS-1:0] len; bit mmio;} hdr_t;
   typedef struct {logic [IWIDTH-1:0] data; bit last;} beat_t;

   wr_t         wr_q[$];
   done_t       done_q[$];
   logic [31:0] mmio_q[$];
   hdr_t        hdr_q[$];
   beat_t       beat_q[$];

   int checks = 0, failures = 0;
   int cyc = 0, wr_count = 0, streak = 0, max_streak = 0, last_wr_cyc = -10, fin_cyc = -10;
   int stall_cycles = 0, ready_mode = 0, stall_at = 0, stall_left = 0;
   int hdr_gap = 0, beat_gap = 0;
   bit prev_stall = 1'b0;
   logic [ADDR_BITS-1:0] prev_addr;
   logic [CWIDTH-1:0]    prev_data;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Cache-port ready: always granted, random, or a bounded stall on a chosen write.
   initial begin
      IN_CACHE_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            1: IN_CACHE_ready = ($urandom_range(0, 3) != 0);
            2: if (wr_count == stall_at && stall_left > 0) begin
                  IN_CACHE_ready = 1'b0;
                  stall_left--;
               end else begin
                  IN_CACHE_ready = 1'b1;
               end
            default: IN_CACHE_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clk) begin : monitor
      done_t d;
      wr_t   w;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (OUT_done) begin
            if (done_q.size() == 0) begin
               fail_now($sformatf("unexpected_done id=%0d required=none", OUT_doneId));
            end else begin
               d = done_q.pop_front();
               check("done_id", OUT_doneId, d.id);
               if (d.mmio) check("done_with_mmio_valid", OUT_mmioValid, 1);
               else        check("done_latency_cycle", cyc, fin_cyc + 1);
            end
         end
         if (OUT_mmioValid) begin
            if (mmio_q.size() == 0) fail_now($sformatf("unexpected_mmio data=0x%0h required=none", OUT_mmioData));
            else check("mmio_data", OUT_mmioData, mmio_q.pop_front());
         end
         if (prev_stall) begin
            check("stall_hold_ce", OUT_CACHE_ce, 0);
            check("stall_hold_addr", OUT_CACHE_addr, prev_addr);
            check("stall_hold_data", OUT_CACHE_data, prev_data);
         end
         if (!OUT_CACHE_ce) begin
            check("we_with_ce", OUT_CACHE_we, 0);
            if (IN_CACHE_ready) begin
               if (wr_q.size() == 0) begin
                  fail_now($sformatf("unexpected_write addr=0x%0h required=none", OUT_CACHE_addr));
               end else begin
                  w = wr_q.pop_front();
                  check("write_addr", OUT_CACHE_addr, w.addr);
                  check("write_data", OUT_CACHE_data, w.data);
                  if (w.last) fin_cyc = cyc;
               end
               wr_count++;
               streak = (last_wr_cyc == cyc - 1) ? streak + 1 : 1;
               if (streak > max_streak) max_streak = streak;
               last_wr_cyc = cyc;
            end else begin
               stall_cycles++;
            end
         end
         prev_stall = !OUT_CACHE_ce && !IN_CACHE_ready;
         prev_addr  = OUT_CACHE_addr;
         prev_data  = OUT_CACHE_data;
      end
   end

   // Transfer-level model: word k of a transfer lands at the start address with its
   // line offset advanced by k modulo the line size; MMIO takes the low 32 bits of one beat.
   task automatic plan_xfer(input int id, input int addr, input int len, input bit mmio,
                            input bit use_first, input logic [IWIDTH-1:0] first);
      logic [IWIDTH-1:0] beats[$];
      int nb;
      nb = mmio ? 1 : (len + WNUM) / WNUM;
      for (int b = 0; b < nb; b++) begin
         logic [IWIDTH-1:0] d;
         d = {$urandom, $urandom, $urandom, $urandom};
         if (b == 0 && use_first) d = first;
         beats.push_back(d);
         beat_q.push_back('{d, b == nb - 1});
      end
      if (mmio) begin
         mmio_q.push_back(beats[0][31:0]);
         done_q.push_back('{id[ID_LEN-1:0], 1'b1});
      end else begin
         for (int k = 0; k <= len; k++) begin
            int a;
            logic [IWIDTH-1:0] bd;
            a  = (addr / LINE) * LINE + ((addr % LINE) + k) % LINE;
            bd = beats[k / WNUM];
            wr_q.push_back('{a[ADDR_BITS-1:0], bd[(k % WNUM)*CWIDTH +: CWIDTH], k == len});
         end
         done_q.push_back('{id[ID_LEN-1:0], 1'b0});
      end
      hdr_q.push_back('{id[ID_LEN-1:0], addr[ADDR_BITS-1:0], len[LEN_BITS-1:0], mmio});
   endtask

   task automatic send_hdr(input hdr_t h);
      int n = 0;
      IN_valid = 1'b1; IN_id = h.id; IN_addr = h.addr; IN_len = h.len; IN_mmio = h.mmio;
      @(negedge clk);
      while (!OUT_ready && n < 3000) begin n++; @(negedge clk); end
      if (!OUT_ready) fail_now("header_accept_timeout");
      @(posedge clk); #1;
      IN_valid = 1'b0;
   endtask

   task automatic send_beat(input beat_t bt);
      int n = 0;
      IN_dataValid = 1'b1; IN_data = bt.data; IN_last = bt.last;
      @(negedge clk);
      while (!OUT_dataReady && n < 3000) begin n++; @(negedge clk); end
      if (!OUT_dataReady) fail_now("beat_accept_timeout");
      @(posedge clk); #1;
      IN_dataValid = 1'b0;
   endtask

   task automatic run_headers();
      @(posedge clk); #1;
      while (hdr_q.size() != 0) begin
         hdr_t h;
         h = hdr_q.pop_front();
         repeat ($urandom_range(0, hdr_gap)) begin @(posedge clk); #1; end
         send_hdr(h);
      end
   endtask

   task automatic run_beats();
      @(posedge clk); #1;
      while (beat_q.size() != 0) begin
         beat_t bt;
         bt = beat_q.pop_front();
         repeat ($urandom_range(0, beat_gap)) begin @(posedge clk); #1; end
         send_beat(bt);
      end
   endtask

   task automatic run_all();
      fork
         run_headers();
         run_beats();
      join
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while ((wr_q.size() + done_q.size() + mmio_q.size()) != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if ((wr_q.size() + done_q.size() + mmio_q.size()) != 0) begin
         fail_now($sformatf("drain_timeout writes_left=%0d dones_left=%0d required=0",
                            wr_q.size(), done_q.size()));
         wr_q.delete(); done_q.delete(); mmio_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int base;
      IN_valid = 1'b0; IN_id = '0; IN_len = '0; IN_addr = '0; IN_mmio = 1'b0;
      IN_dataValid = 1'b0; IN_data = '0; IN_last = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ce", OUT_CACHE_ce, 1);
      check("reset_we", OUT_CACHE_we, 1);
      check("reset_done", OUT_done, 0);
      check("reset_mmio_valid", OUT_mmioValid, 0);
      check("reset_ready", OUT_ready, 1);
      check("reset_data_ready", OUT_dataReady, 1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("idle_ce", OUT_CACHE_ce, 1);

      // Single beat, four consecutive writes, done right after the last one.
      max_streak = 0;
      plan_xfer(1, 'h020, 3, 1'b0, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
      run_all();
      wait_drain(200);
      check("basic_gapless_writes", max_streak, 4);

      // Line wrap from the top of the line.
      plan_xfer(2, 'h03E, 3, 1'b0, 1'b0, '0);
      run_all();
      wait_drain(200);

      // Three-cycle stall on word 1; len=1 drops the rest of the beat.
      stall_at = wr_count + 1; stall_left = 3; stall_cycles = 0; ready_mode = 2;
      plan_xfer(3, 'h050, 1, 1'b0, 1'b0, '0);
      plan_xfer(0, 'h065, 2, 1'b0, 1'b0, '0);
      run_all();
      wait_drain(200);
      check("stall_cycle_count", stall_cycles, 3);
      ready_mode = 0;

      // Back-to-back transfers fill both slots and stream without gaps.
      max_streak = 0;
      plan_xfer(1, 'h100, 7, 1'b0, 1'b0, '0);
      plan_xfer(2, 'h204, 3, 1'b0, 1'b0, '0);
      fork
         begin
            run_headers();
            @(negedge clk);
            check("ready_low_both_slots_full", OUT_ready, 0);
         end
         run_beats();
      join
      wait_drain(200);
      check("b2b_gapless_writes", max_streak, 12);
      check("ready_after_b2b", OUT_ready, 1);

      // MMIO transfer: no cache access, data on the side port.
      plan_xfer(3, 'h000, 5, 1'b1, 1'b1, {96'h0, 32'h12345678});
      run_all();
      wait_drain(200);

      // Randomized mix of cache and MMIO transfers with random gaps and stalls.
      ready_mode = 1; hdr_gap = 3; beat_gap = 3;
      for (int t = 0; t < 40; t++) begin
         int len;
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 15);
         plan_xfer($urandom_range(0, 3), $urandom_range(0, 1023), len,
                   $urandom_range(0, 5) == 0, 1'b0, '0);
      end
      run_all();
      wait_drain(20000);
      ready_mode = 0; hdr_gap = 0; beat_gap = 0;

      // Reset in the middle of a transfer: write abandoned, no done pulse.
      base = wr_count;
      plan_xfer(2, 'h0A0, 3, 1'b0, 1'b0, '0);
      run_all();
      begin
         int n = 0;
         while (wr_count < base + 2 && n < 200) begin @(negedge clk); n++; end
         if (wr_count < base + 2) fail_now("reset_test_write_timeout");
      end
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_mid_ce", OUT_CACHE_ce, 1);
      check("reset_mid_ready", OUT_ready, 1);
      check("reset_mid_done", OUT_done, 0);
      wr_q.delete(); done_q.delete(); mmio_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("after_reset_ce", OUT_CACHE_ce, 1);
      check("after_reset_data_ready", OUT_dataReady, 1);
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
